// File: rtl/wb_pkg.sv
// Shared definitions for the register writeback path: register-address geometry,
// the hard-wired zero register and the queued writeback entry layout.
package wb_pkg;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int WB_N     = 32;
  localparam logic [REG_AW-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [WB_N-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; also exposes every slot and a per-slot
// valid vector so the owner can build a pending-destination bitmap.
module wb_fifo #(
  parameter  int W     = 37,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [W-1:0]              din_i,
  input  logic                      pop_i,
  output logic [W-1:0]              dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [CW-1:0]             count_o,
  output logic [DEPTH-1:0]          vld_o,
  output logic [DEPTH-1:0][W-1:0]   ents_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic                    do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    vld_d = vld_q;
    if (do_pop)  vld_d[rd_ptr_q] = 1'b0;
    if (do_push) vld_d[wr_ptr_q] = 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload storage carries no reset; slot validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign vld_o   = vld_q;
  assign ents_o  = mem_q;
endmodule

// File: rtl/reg_writeback.sv
// Writeback controller: arbitrates ALU and load results (load first), drops x0
// writes, queues the rest and drains one per cycle onto the register-file port.
module reg_writeback
  import wb_pkg::*;
#(
  parameter  int N     = 32,
  parameter  int DEPTH = 4,
  parameter  int AW    = REG_AW,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_rd,
  input  logic [N-1:0]      alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [AW-1:0]     mem_rd,
  input  logic [N-1:0]      mem_data,
  output logic [AW-1:0]     rd,
  output logic [N-1:0]      write_data,
  output logic              reg_write,
  output logic [2**AW-1:0]  busy,
  output logic [CW-1:0]     count
);
  localparam int EW = AW + N;

  logic                    full, empty, pop, push;
  logic                    mem_hs, alu_hs;
  logic [AW-1:0]           push_rd;
  logic [N-1:0]            push_data;
  logic [EW-1:0]           head;
  logic [DEPTH-1:0]        ent_vld;
  logic [DEPTH-1:0][EW-1:0] ents;
  logic [AW-1:0]           rd_q, rd_d;
  logic [N-1:0]            wdata_q, wdata_d;
  logic                    reg_write_q, reg_write_d;
  logic [2**AW-1:0]        busy_c;

  // Ready looks only at the registered fill level, so a full queue never
  // accepts even when it is draining in the same cycle.
  assign mem_ready = !full && !rst;
  assign alu_ready = !full && !mem_valid && !rst;
  assign mem_hs    = mem_valid && mem_ready;
  assign alu_hs    = alu_valid && alu_ready;
  assign push_rd   = mem_hs ? mem_rd   : alu_rd;
  assign push_data = mem_hs ? mem_data : alu_data;
  assign push      = (mem_hs || alu_hs) && (push_rd != AW'(X0));
  assign pop       = !empty;

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({push_rd, push_data}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .vld_o   (ent_vld),
    .ents_o  (ents)
  );

  always_comb begin
    reg_write_d = pop;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    if (pop) begin
      rd_d    = head[EW-1:N];
      wdata_d = head[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    busy_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) busy_c[ents[i][EW-1:N]] = 1'b1;
    end
    if (reg_write_q) busy_c[rd_q] = 1'b1;
    busy_c[0] = 1'b0;
  end

  assign rd         = rd_q;
  assign write_data = wdata_q;
  assign reg_write  = reg_write_q;
  assign busy       = busy_c;
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: queue-based reference model, per-cycle state checks
// and a scoreboard monitor that pops expected writes whenever reg_write is high.
module tb_reg_writeback;
  import wb_pkg::*;

  localparam int N = 32, DEPTH = 4, AW = 5, CW = 3;

  logic          clk, rst;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd, rd;
  logic [N-1:0]  alu_data, mem_data, write_data;
  logic          reg_write;
  logic [31:0]   busy;
  logic [CW-1:0] count;

  reg_writeback #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rd(rd), .write_data(write_data), .reg_write(reg_write), .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_entry_t     mq[$];
  wb_entry_t     exp_q[$];
  bit            pres_v;
  logic [AW-1:0] last_rd;
  logic [N-1:0]  last_data;
  bit            last_alu_acc, last_mem_acc;
  bit            started;
  int            tests, fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_mem_rdy();
    return !rst && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_alu_rdy();
    return m_mem_rdy() && !mem_valid;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    foreach (mq[i]) b[mq[i].rd] = 1'b1;
    if (pres_v) b[last_rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // Advance the reference model across one rising edge using the inputs held there.
  task automatic model_update();
    bit am, aa;
    wb_entry_t e;
    am = mem_valid && m_mem_rdy();
    aa = alu_valid && m_alu_rdy();
    last_mem_acc = am;
    last_alu_acc = aa;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      pres_v    = 1'b0;
      last_rd   = '0;
      last_data = '0;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        pres_v    = 1'b1;
        last_rd   = e.rd;
        last_data = e.data;
      end else begin
        pres_v = 1'b0;
      end
      if (am || aa) begin
        e.rd   = am ? mem_rd : alu_rd;
        e.data = am ? mem_data : alu_data;
        if (e.rd != 0) begin
          mq.push_back(e);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    started = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("alu_ready",  64'(alu_ready),  64'(m_alu_rdy()));
      check("mem_ready",  64'(mem_ready),  64'(m_mem_rdy()));
      check("count",      64'(count),      64'(mq.size()));
      check("busy",       64'(busy),       64'(m_busy()));
      check("reg_write",  64'(reg_write),  64'(pres_v));
      check("rd",         64'(rd),         64'(last_rd));
      check("write_data", 64'(write_data), 64'(last_data));
    end
  end

  always @(negedge clk) begin
    wb_entry_t e;
    if (started && reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_rd",   64'(rd),         64'(e.rd));
        check("sb_data", 64'(write_data), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    started   = 1'b0;
    tests     = 0;
    fails     = 0;
    pres_v    = 1'b0;
    last_rd   = '0;
    last_data = '0;
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    repeat (3) tick();
    check("rst_count", 64'(count), 64'(0));
    check("rst_regw",  64'(reg_write), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_ready", 64'(mem_ready), 64'(0));
    rst = 1'b0;
    tick();

    // Single ALU write: two edges to reg_write, busy from the cycle after acceptance.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
    #1 check("t1_ready", 64'(alu_ready), 64'(1));
    tick();
    alu_valid = 1'b0;
    check("t1_busy_early", 64'(busy[5]), 64'(1));
    check("t1_regw_early", 64'(reg_write), 64'(0));
    tick();
    check("t1_regw", 64'(reg_write), 64'(1));
    check("t1_rd",   64'(rd), 64'(5));
    check("t1_data", 64'(write_data), 64'(32'hAA));
    check("t1_busy_pres", 64'(busy[5]), 64'(1));
    tick();
    check("t1_regw_done", 64'(reg_write), 64'(0));
    check("t1_count", 64'(count), 64'(0));
    check("t1_busy_clr", 64'(busy), 64'(0));

    // Load beats ALU when both are offered.
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'd7;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd9;
    #1;
    check("t2_mem_ready", 64'(mem_ready), 64'(1));
    check("t2_alu_ready", 64'(alu_ready), 64'(0));
    tick();
    mem_valid = 1'b0;
    #1 check("t2_alu_ready2", 64'(alu_ready), 64'(1));
    tick();
    alu_valid = 1'b0;
    repeat (3) tick();

    // Back-to-back ALU writes r1..r6.
    alu_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      alu_rd = AW'(k); alu_data = N'(10 + k);
      guard = 0;
      do begin
        tick();
        guard++;
      end while (!last_alu_acc && guard < 20);
      if (!last_alu_acc) check("t3_accept_timeout", 64'(0), 64'(1));
    end
    alu_valid = 1'b0;
    repeat (4) tick();

    // x0 write is accepted but never reaches the port.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    #1 check("t4_ready", 64'(alu_ready), 64'(1));
    tick();
    alu_valid = 1'b0;
    check("t4_count", 64'(count), 64'(0));
    check("t4_busy",  64'(busy), 64'(0));
    tick();
    check("t4_regw",  64'(reg_write), 64'(0));
    tick();

    // Zero data is a legal result.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'd0;
    tick();
    alu_valid = 1'b0;
    tick();
    check("t5_regw", 64'(reg_write), 64'(1));
    check("t5_rd",   64'(rd), 64'(9));
    check("t5_data", 64'(write_data), 64'(0));
    tick();

    // Reset in the middle of a drain discards everything pending.
    alu_valid = 1'b1;
    alu_rd = 5'd7;  alu_data = 32'h70; tick();
    alu_rd = 5'd8;  alu_data = 32'h80; tick();
    alu_rd = 5'd10; alu_data = 32'hA0; tick();
    alu_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_regw",  64'(reg_write), 64'(0));
    check("t6_count", 64'(count), 64'(0));
    check("t6_busy",  64'(busy), 64'(0));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_no_write", 64'(reg_write), 64'(0));
    end

    // Randomised traffic with producers holding until accepted.
    for (int c = 0; c < 3000; c++) begin
      if (!mem_valid || last_mem_acc) begin
        mem_valid = ($urandom_range(0, 2) == 0);
        mem_rd    = AW'($urandom_range(0, 31));
        mem_data  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom());
      end
      if (!alu_valid || last_alu_acc) begin
        alu_valid = ($urandom_range(0, 1) == 0);
        alu_rd    = AW'($urandom_range(0, 31));
        alu_data  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom());
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (6) tick();
    check("final_sb_empty", 64'(exp_q.size()), 64'(0));
    check("final_count",    64'(count), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback controller for the multi-cycle processor. It is the write-side counterpart of the register file.
- Accepts result writes from two producers: the ALU path and the memory-load path. Each uses a valid/ready handshake.
- Accepted results go into a small FIFO. The FIFO drains one entry per cycle onto the register file write port (rd, write_data, reg_write).
- Publishes a busy bitmap of destinations still pending so decode can stall on RAW hazards.

Parameters:
- N, 32, data width of a register.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 5, register address width (32 architectural registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  N  ALU result.
- mem_valid  in  1  load result present.
- mem_ready  out  1  load result accepted this cycle when mem_valid is also high.
- mem_rd  in  AW  load destination register.
- mem_data  in  N  load data.
- rd  out  AW  register file write address.
- write_data  out  N  register file write data.
- reg_write  out  1  register file write enable; high for exactly one cycle per write.
- busy  out  2**AW  bit i high means a write to register i is queued or being presented.
- count  out  log2(DEPTH)+1  number of FIFO entries in use.

Behaviour:
- Reset: all registered state clears on the rising clk edge while rst=1.
  - Pointers, count, rd, write_data, reg_write and busy all go to 0.
  - alu_ready and mem_ready are forced 0 while rst=1.
  - Reset mid-operation discards all queued entries. No write issues in the cycle after reset.
- Acceptance: at most one push per cycle.
  - mem_ready = !full && !rst.
  - alu_ready = !full && !mem_valid && !rst. A load has fixed priority over the ALU.
  - A handshake is valid&&ready sampled at the rising edge. The producer holds rd/data stable until accepted.
- Full means count==DEPTH. There is no push-through when full, even if a pop happens that cycle. Ready depends only on the registered count.
- x0 filtering: a handshake with rd==0 completes normally but is not enqueued. count, busy and reg_write are unaffected.
- Zero data: a write_data value of 0 is a legal result and is enqueued and written normally.
- Drain: each cycle, if count>0 the head is popped and its rd/data are registered onto rd/write_data with reg_write=1. Otherwise reg_write=0, and rd/write_data hold their last values.
- Latency: with the FIFO empty, a push accepted at edge E presents reg_write=1 during the cycle after edge E+1. The register file commits at edge E+2.
- Simultaneous push and pop: both happen; count is unchanged.
- Order: writes appear on the write port in acceptance order. Throughput is 1 write/cycle sustained.
- Pointers wrap modulo DEPTH.
- busy is combinational from registered state: the OR of one-hot(rd) over all valid FIFO entries, plus one-hot(rd) when reg_write=1. Bit 0 is always 0.
- A producer sees busy for its own write no earlier than the cycle after acceptance.

Decomposition:
- Shared package/header (wb_pkg): REG_AW=5, NUM_REGS=32, the X0 constant, and a writeback entry record {rd[AW-1:0], data[N-1:0]}.
- Sub-module wb_fifo: synchronous FIFO of entries with push/pop/full/empty/count, plus an entry-valid vector for busy generation.
- reg_writeback owns arbitration, x0 filtering, output registers and busy.

Test Plan:
- Reset, then a single ALU write with alu_rd=5, alu_data=32'h0000_00AA → reg_write=1 with rd=5, write_data=AA exactly 2 edges after acceptance. busy[5]=1 from the cycle after acceptance until reg_write drops. Then count=0 and busy=0.
- mem_valid and alu_valid high together (mem_rd=3/data 7, alu_rd=4/data 9) → mem_ready=1, alu_ready=0. Write order is r3=7, then r4=9 after the ALU is accepted next cycle.
- Push 6 back-to-back ALU writes to r1..r6 with data 11..16 → ready drops only when count reaches 4. All 6 writes appear in order with no loss or duplication; reg_write is high for 6 consecutive cycles after the first write appears.
- ALU write with rd=0, data 32'hDEAD_BEEF → handshake completes; count stays 0, busy stays 0, no reg_write pulse.
- ALU write with rd=9, data 0 → reg_write pulse with rd=9, write_data=0.
- Queue 3 entries, assert rst for 1 cycle mid-drain → reg_write=0, count=0, busy=0 after the reset edge. No further writes issue until new handshakes occur.
